// File: rtl/vga_timing_ctrl.sv
// VGA pixel/line sequencer with frame-synchronous background/splash registers.
// Define VGA_IRQ_EN to build the vblank interrupt request/acknowledge logic.
module vga_timing_ctrl #(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned H_VIS   = 640,
   parameter int unsigned H_FP    = 16,
   parameter int unsigned H_SYNC  = 96,
   parameter int unsigned H_BP    = 48,
   parameter int unsigned V_VIS   = 480,
   parameter int unsigned V_FP    = 10,
   parameter int unsigned V_SYNC  = 2,
   parameter int unsigned V_BP    = 33
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cfg_we,
   input  logic       cfg_addr,
   input  logic [4:0] cfg_wdata,
   input  logic       irq_ack,
   output logic       pix_en,
   output logic [9:0] counter_x,
   output logic [8:0] counter_y,
   output logic       hsync,
   output logic       vsync,
   output logic       ins,
   output logic       frame_start,
   output logic [4:0] bcgcol,
   output logic       splash,
   output logic       vblank_irq
);

   localparam int unsigned DivW = $clog2(CLK_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

   localparam logic [9:0] HVisLast  = 10'(H_VIS - 1);
   localparam logic [9:0] HFpLast   = 10'(H_FP - 1);
   localparam logic [9:0] HSyncLast = 10'(H_SYNC - 1);
   localparam logic [9:0] HBpLast   = 10'(H_BP - 1);
   localparam logic [9:0] VVisLast  = 10'(V_VIS - 1);
   localparam logic [9:0] VFpLast   = 10'(V_FP - 1);
   localparam logic [9:0] VSyncLast = 10'(V_SYNC - 1);
   localparam logic [9:0] VBpLast   = 10'(V_BP - 1);

   typedef enum logic [1:0] {HVis, HFront, HSync, HBack} h_state_e;
   typedef enum logic [1:0] {VVis, VFront, VSync, VBack} v_state_e;

   logic [DivW-1:0] div_q, div_d;
   h_state_e        h_state_q, h_state_d;
   v_state_e        v_state_q, v_state_d;
   logic [9:0]      h_phase_q, h_phase_d, v_phase_q, v_phase_d;
   logic [9:0]      h_last, v_last;
   logic            tick, h_wrap, v_wrap, line_end, commit, frame_wrap;

   logic            pix_en_q, hsync_q, vsync_q, ins_q, frame_start_q;
   logic            hsync_d, vsync_d, ins_d;
   logic [9:0]      counter_x_q, counter_x_d;
   logic [8:0]      counter_y_q, counter_y_d;

   logic [4:0]      bcg_pend_q, bcg_pend_d, bcgcol_q, bcgcol_d;
   logic            splash_pend_q, splash_pend_d, splash_q, splash_d;
   logic            dirty_q, dirty_d;

   always_comb begin
      tick  = (div_q == DivLast);
      div_d = tick ? '0 : div_q + DivW'(1);

      case (h_state_q)
         HVis:    h_last = HVisLast;
         HFront:  h_last = HFpLast;
         HSync:   h_last = HSyncLast;
         default: h_last = HBpLast;
      endcase
      case (v_state_q)
         VVis:    v_last = VVisLast;
         VFront:  v_last = VFpLast;
         VSync:   v_last = VSyncLast;
         default: v_last = VBpLast;
      endcase

      h_wrap     = (h_phase_q == h_last);
      v_wrap     = (v_phase_q == v_last);
      line_end   = h_wrap && (h_state_q == HBack);
      commit     = tick && line_end && v_wrap && (v_state_q == VVis);
      frame_wrap = tick && line_end && v_wrap && (v_state_q == VBack);

      h_state_d = h_state_q;
      h_phase_d = h_phase_q;
      v_state_d = v_state_q;
      v_phase_d = v_phase_q;
      if (tick) begin
         if (h_wrap) begin
            h_phase_d = '0;
            case (h_state_q)
               HVis:    h_state_d = HFront;
               HFront:  h_state_d = HSync;
               HSync:   h_state_d = HBack;
               default: h_state_d = HVis;
            endcase
         end else begin
            h_phase_d = h_phase_q + 10'd1;
         end
         // The vertical FSM only moves on the last pixel of the back porch.
         if (line_end) begin
            if (v_wrap) begin
               v_phase_d = '0;
               case (v_state_q)
                  VVis:    v_state_d = VFront;
                  VFront:  v_state_d = VSync;
                  VSync:   v_state_d = VBack;
                  default: v_state_d = VVis;
               endcase
            end else begin
               v_phase_d = v_phase_q + 10'd1;
            end
         end
      end

      counter_x_d = (h_state_d == HVis) ? h_phase_d : HVisLast;
      counter_y_d = (v_state_d == VVis) ? v_phase_d[8:0] : 9'(V_VIS - 1);
      hsync_d     = (h_state_d != HSync);
      vsync_d     = (v_state_d != VSync);
      ins_d       = (h_state_d == HVis) && (v_state_d == VVis);
   end

   // Commit reads the pre-write pending copy; a coinciding write keeps dirty set.
   always_comb begin
      bcg_pend_d    = bcg_pend_q;
      splash_pend_d = splash_pend_q;
      dirty_d       = dirty_q;
      bcgcol_d      = bcgcol_q;
      splash_d      = splash_q;
      if (commit && dirty_q) begin
         bcgcol_d = bcg_pend_q;
         splash_d = splash_pend_q;
         dirty_d  = 1'b0;
      end
      if (cfg_we) begin
         dirty_d = 1'b1;
         if (cfg_addr) begin
            splash_pend_d = cfg_wdata[0];
         end else begin
            bcg_pend_d = cfg_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q         <= '0;
         h_state_q     <= HVis;
         h_phase_q     <= '0;
         v_state_q     <= VVis;
         v_phase_q     <= '0;
         pix_en_q      <= 1'b0;
         counter_x_q   <= '0;
         counter_y_q   <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         ins_q         <= 1'b1;
         frame_start_q <= 1'b0;
         bcg_pend_q    <= '0;
         splash_pend_q <= 1'b0;
         dirty_q       <= 1'b0;
         bcgcol_q      <= '0;
         splash_q      <= 1'b0;
      end else begin
         div_q         <= div_d;
         h_state_q     <= h_state_d;
         h_phase_q     <= h_phase_d;
         v_state_q     <= v_state_d;
         v_phase_q     <= v_phase_d;
         pix_en_q      <= tick;
         counter_x_q   <= counter_x_d;
         counter_y_q   <= counter_y_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         ins_q         <= ins_d;
         frame_start_q <= frame_wrap;
         bcg_pend_q    <= bcg_pend_d;
         splash_pend_q <= splash_pend_d;
         dirty_q       <= dirty_d;
         bcgcol_q      <= bcgcol_d;
         splash_q      <= splash_d;
      end
   end

`ifdef VGA_IRQ_EN
   logic irq_q;

   // Set has priority over a coinciding acknowledge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q <= 1'b0;
      end else if (commit) begin
         irq_q <= 1'b1;
      end else if (irq_ack) begin
         irq_q <= 1'b0;
      end
   end

   assign vblank_irq = irq_q;
`else
   logic unused_irq_ack;

   assign unused_irq_ack = irq_ack;
   assign vblank_irq     = 1'b0;
`endif

   assign pix_en      = pix_en_q;
   assign counter_x   = counter_x_q;
   assign counter_y   = counter_y_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign ins         = ins_q;
   assign frame_start = frame_start_q;
   assign bcgcol      = bcgcol_q;
   assign splash      = splash_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a shrunken raster (15x13 pixels, 3 clks per pixel).
// Expected interrupt levels follow whether VGA_IRQ_EN is defined for the build.
module tb_vga_timing_ctrl;

   localparam int CLK_DIV = 3;
   localparam int H_VIS = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
   localparam int V_VIS = 6, V_FP = 2, V_SYNC = 2, V_BP = 3;
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int FRAME = H_TOT * V_TOT;
   localparam int WAIT_MAX = 3 * FRAME * CLK_DIV;
`ifdef VGA_IRQ_EN
   localparam int IrqOn = 1;
`else
   localparam int IrqOn = 0;
`endif

   logic       clk = 1'b0;
   logic       rst, cfg_we, cfg_addr, irq_ack;
   logic [4:0] cfg_wdata;
   logic       pix_en, hsync, vsync, ins, frame_start, splash, vblank_irq;
   logic [9:0] counter_x;
   logic [8:0] counter_y;
   logic [4:0] bcgcol;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference raster position and running statistics, owned by the monitor.
   int bx = 0, by = 0, gap = 0, map_err = 0, div_err = 0;
   int ins_cnt = 0, hs_cnt = 0, vs_cnt = 0;

   vga_timing_ctrl #(
      .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .irq_ack(irq_ack), .pix_en(pix_en), .counter_x(counter_x), .counter_y(counter_y),
      .hsync(hsync), .vsync(vsync), .ins(ins), .frame_start(frame_start), .bcgcol(bcgcol),
      .splash(splash), .vblank_irq(vblank_irq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_pix_en"}, pix_en, 0);
      check_eq({tag, "_x"}, counter_x, 0);
      check_eq({tag, "_y"}, counter_y, 0);
      check_eq({tag, "_hsync"}, hsync, 1);
      check_eq({tag, "_vsync"}, vsync, 1);
      check_eq({tag, "_ins"}, ins, 1);
      check_eq({tag, "_fs"}, frame_start, 0);
      check_eq({tag, "_bcg"}, bcgcol, 0);
      check_eq({tag, "_splash"}, splash, 0);
      check_eq({tag, "_irq"}, vblank_irq, 0);
   endtask

   // Stops on the pix_en sample that has just entered raster position (x, y).
   task automatic wait_pos(input int x, input int y, input string tag);
      int found = 0;
      for (int i = 0; i < WAIT_MAX && found == 0; i++) begin
         step();
         if (pix_en && bx == x && by == y) found = 1;
      end
      check_eq(tag, found, 1);
   endtask

   task automatic run_to_fs(output int pes);
      int seen = 0;
      pes = 0;
      for (int i = 0; i < WAIT_MAX && seen == 0; i++) begin
         step();
         if (pix_en) pes++;
         if (frame_start) seen = 1;
      end
   endtask

   task automatic cfg_write(input logic addr, input logic [4:0] data);
      cfg_addr  = addr;
      cfg_wdata = data;
      cfg_we    = 1'b1;
      step();
      cfg_we    = 1'b0;
   endtask

   // Raster monitor: advances on every pix_en and compares all timing outputs.
   initial begin
      int ex, ey, ehs, evs, eins, efs;
      forever begin
         @(negedge clk);
         if (rst) begin
            bx  = 0;
            by  = 0;
            gap = 0;
         end else begin
            gap++;
            if (pix_en) begin
               if (gap != CLK_DIV) div_err++;
               gap = 0;
               if (bx == H_TOT - 1) begin
                  bx = 0;
                  by = (by == V_TOT - 1) ? 0 : by + 1;
               end else begin
                  bx++;
               end
               if (ins) ins_cnt++;
               if (!hsync) hs_cnt++;
               if (!vsync) vs_cnt++;
            end
            ex   = (bx < H_VIS) ? bx : H_VIS - 1;
            ey   = (by < V_VIS) ? by : V_VIS - 1;
            ehs  = (bx >= H_VIS + H_FP && bx < H_VIS + H_FP + H_SYNC) ? 0 : 1;
            evs  = (by >= V_VIS + V_FP && by < V_VIS + V_FP + V_SYNC) ? 0 : 1;
            eins = (bx < H_VIS && by < V_VIS) ? 1 : 0;
            efs  = (pix_en && bx == 0 && by == 0) ? 1 : 0;
            if (int'(counter_x) != ex || int'(counter_y) != ey || int'(hsync) != ehs ||
                int'(vsync) != evs || int'(ins) != eins || int'(frame_start) != efs)
               map_err++;
         end
      end
   end

   initial begin
      int n, pes, s_ins, s_hs, s_vs;
      rst = 1'b1; cfg_we = 1'b0; cfg_addr = 1'b0; cfg_wdata = '0; irq_ack = 1'b0;
      repeat (3) step();
      check_reset("por");

      rst = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (!pix_en && n < 100);
      check_eq("first_pix_en_clks", n, CLK_DIV);
      run_to_fs(pes);
      check_eq("pix_en_to_first_fs", pes + 1, FRAME);

      s_ins = ins_cnt; s_hs = hs_cnt; s_vs = vs_cnt;
      run_to_fs(pes);
      check_eq("frame_pix_en", pes, FRAME);
      check_eq("frame_ins_pixels", ins_cnt - s_ins, H_VIS * V_VIS);
      check_eq("frame_hsync_low", hs_cnt - s_hs, H_SYNC * V_TOT);
      check_eq("frame_vsync_low", vs_cnt - s_vs, V_SYNC * H_TOT);

      wait_pos(H_VIS + H_FP - 1, 0, "wait_pre_hs");
      check_eq("hsync_before_start", hsync, 1);
      wait_pos(H_VIS + H_FP, 0, "wait_hs");
      check_eq("hsync_at_start", hsync, 0);
      check_eq("x_in_hblank", counter_x, H_VIS - 1);

      // Drop the interrupt left over from the previous commit.
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      check_eq("irq_cleared", vblank_irq, 0);

      wait_pos(0, 1, "wait_line1");
      cfg_write(1'b0, 5'd19);
      check_eq("bcg_pending_hidden", bcgcol, 0);
      wait_pos(H_TOT - 1, V_VIS - 1, "wait_pre_commit");
      check_eq("bcg_before_commit", bcgcol, 0);
      check_eq("irq_before_commit", vblank_irq, 0);
      wait_pos(0, V_VIS, "wait_commit");
      check_eq("bcg_after_commit", bcgcol, 19);
      check_eq("irq_rise", vblank_irq, IrqOn);
      check_eq("y_in_vblank", counter_y, V_VIS - 1);
      step();
      step();
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      check_eq("irq_ack_drop", vblank_irq, 0);

      cfg_write(1'b0, 5'd7);
      cfg_write(1'b1, 5'b11101);
      wait_pos(H_TOT - 1, V_VIS - 1, "wait_pre_commit2");
      check_eq("bcg_hold_19", bcgcol, 19);
      check_eq("splash_hold_0", splash, 0);
      repeat (CLK_DIV - 1) step();
      cfg_addr = 1'b0; cfg_wdata = 5'd9; cfg_we = 1'b1; irq_ack = 1'b1;
      step();
      cfg_we = 1'b0; irq_ack = 1'b0;
      check_eq("commit_edge_aligned", pix_en, 1);
      check_eq("bcg_pre_write_value", bcgcol, 7);
      check_eq("splash_bit0_only", splash, 1);
      check_eq("irq_set_beats_ack", vblank_irq, IrqOn);
      wait_pos(0, V_VIS + 1, "wait_after_commit2");
      check_eq("bcg_still_7", bcgcol, 7);
      irq_ack = 1'b1;
      step();
      irq_ack = 1'b0;
      check_eq("irq_ack_drop2", vblank_irq, 0);
      wait_pos(0, V_VIS, "wait_commit3");
      check_eq("bcg_next_frame_9", bcgcol, 9);
      check_eq("splash_kept", splash, 1);

      cfg_write(1'b0, 5'd21);
      wait_pos(5, 3, "wait_mid_frame");
      rst = 1'b1;
      #1;
      check_reset("async_rst");
      step();
      step();
      rst = 1'b0;
      run_to_fs(pes);
      check_eq("pix_en_to_fs_after_rst", pes, FRAME);
      check_eq("pending_lost", bcgcol, 0);

      check_eq("raster_map_errors", map_err, 0);
      check_eq("pix_en_spacing_errors", div_err, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Sequencer and configuration front-end for the VGA output pipeline. It generates the pixel strobe, the visible-area pixel coordinates, hsync/vsync and the `ins` (inside-visible) flag that drive the colour/mixer/output stages. It also holds the frame-global display registers (background colour, splash enable). CPU writes to those registers land in a pending copy and become active only at the start of vertical blank, so a frame never shows a mid-frame change. An optional vblank interrupt with a request/acknowledge handshake is included.

## Interface
Parameters:
- `CLK_DIV`, 2: clk cycles per pixel (≥2).
- `H_VIS`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal phase lengths in pixels.
- `V_VIS`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical phase lengths in lines.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high. Clock is `clk`.
- `cfg_we`  in  1  register write strobe (one clk).
- `cfg_addr`  in  1  0 = background colour, 1 = control.
- `cfg_wdata`  in  5  write data. Control register: bit0 = splash.
- `irq_ack`  in  1  vblank interrupt acknowledge.
- `pix_en`  out  1  one-clk pixel strobe.
- `counter_x`  out  10  visible column, 0..H_VIS-1; holds H_VIS-1 outside the visible area.
- `counter_y`  out  9  visible row, 0..V_VIS-1; holds V_VIS-1 in vertical blank.
- `hsync`, `vsync`  out  1  sync outputs, active low.
- `ins`  out  1  high when both counters are in the visible area.
- `frame_start`  out  1  one-clk pulse on the pix_en cycle that enters pixel (0,0).
- `bcgcol`  out  5  active background colour.
- `splash`  out  1  active splash enable.
- `vblank_irq`  out  1  interrupt request (level).

## Operation
- Divider counter runs 0..CLK_DIV-1. `pix_en` is registered and high for one clk when the divider reads CLK_DIV-1.
- Horizontal FSM: H_VISIBLE → H_FRONT → H_SYNC → H_BACK → H_VISIBLE.
  - Each state is held for its parameter length, counted in pix_en cycles by an internal 10-bit phase counter.
  - The H_BACK → H_VISIBLE transition advances the vertical FSM by one line.
- Vertical FSM: V_VISIBLE → V_FRONT → V_SYNC → V_BACK → V_VISIBLE, with lengths in lines. Total frame is 800×525 pixels with the default parameters.
- `hsync`=0 only in H_SYNC. `vsync`=0 only in V_SYNC. `ins` = H_VISIBLE ∧ V_VISIBLE.
- Config path:
  - A write updates pending[cfg_addr] and sets `dirty`.
  - Commit event: the pix_en cycle on which V_VISIBLE → V_FRONT. If `dirty`, active ← pending and `dirty` is cleared.
  - If a write coincides with the commit: active takes the pre-write pending values, the new data goes to pending, and `dirty` stays set. That write therefore commits at the next frame.
  - Unused `cfg_wdata` bits of the control register are ignored.
- IRQ handshake:
  - `vblank_irq` is set on the commit event and stays high until `irq_ack` is sampled high.
  - If set and ack occur in the same cycle, set wins.
  - Ack while irq is low has no effect.

## Timing
- Reset values: divider 0; both FSMs in VISIBLE with phase 0; `pix_en`=0, `counter_x`=0, `counter_y`=0, `hsync`=1, `vsync`=1, `ins`=1, `frame_start`=0, `bcgcol`=0, `splash`=0, pending=0, dirty=0, `vblank_irq`=0.
- After reset release, the first `pix_en` occurs on the CLK_DIV-th clk edge.
- All outputs are registered and change only on pix_en cycles, except the `irq_ack` clear (any clk, takes effect next edge) and config pending writes. Coordinates, syncs and `ins` are mutually aligned, with zero relative skew.
- `frame_start` coincides with the pix_en cycle whose next state is (0,0). It does not fire for the reset-entered (0,0).
- `bcgcol`/`splash` change exactly once per frame at most, on the commit edge.
- Asserting reset mid-frame forces the reset values immediately (asynchronously). Pending writes are lost.

## Configuration
- `VGA_IRQ_EN` defined: the vblank interrupt logic is present as described above.
- `VGA_IRQ_EN` undefined: `vblank_irq` is tied to 0, `irq_ack` is ignored, and no interrupt flop exists. The config commit is unaffected.

## Test plan
- Reset, run 2 full frames with default parameters → `pix_en` every 2nd clk; 800 pix_en cycles per line; 525 lines per frame.
- Sync placement check → `hsync` low for exactly 96 pixels starting at pixel 656 of each line; `vsync` low for exactly 2 lines starting at line 490; `ins` high for exactly 640×480 pixels per frame.
- Write bcgcol=5'd19 at line 100 → `bcgcol` stays 0 until the first pix_en of line 480, then reads 19. The IRQ rises on that same edge.
- Write on the exact commit edge (bcgcol=7 pending already, new write 9) → active=7 this frame, 9 at the next frame's commit.
- IRQ: ack 3 clks after the rise → irq drops the next edge. Ack coincident with the next frame's set → irq stays high.
- Assert rst at line 300, pixel 412 → all outputs at reset values within the same cycle. After release, counting resumes from (0,0) and `frame_start` first pulses 420000 pix_en cycles later.
